// File: rtl/uart_pkg.sv
// Purpose : shared UART definitions for the fabric receiver and the planned fabric transmitter.
// Latency : n/a (types, constants and elaboration-time helpers only).
// Backpr. : n/a.
//
// Contents: receiver state encoding, oversampling constants, baud divisor helper,
// 2-of-3 majority helper.
package uart_pkg;

  // 16 sub-bit ticks per bit; bit value taken from ticks 7, 8 and 9 (bit centre).
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

  // Rounded divisor: clk_hz / (baud * OVERSAMPLE), rounded to nearest.
  // 200 MHz / 115200 baud gives 109.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Purpose : first-word-fall-through byte FIFO between the UART receiver and fabric consumers.
// Latency : a push is visible at the head the cycle after it is written into an empty FIFO.
// Backpr. : push_rdy_o low when full and no pop this cycle; the writer then drops the entry.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   push_vld_i/_dat_i/_rdy_o write side (rdy is combinational: not full, or full with a pop)
//   pop_vld_o/_dat_o/_rdy_i  read side; pop when vld && rdy, data forced to 0 when empty
//   count_o                  occupancy, 0..DEPTH
//
// DEPTH must be a power of 2 and at least 2.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_vld_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  output logic                     push_rdy_o,
  output logic                     pop_vld_o,
  output logic [WIDTH-1:0]         pop_dat_o,
  input  logic                     pop_rdy_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop     = !empty && pop_rdy_i;
  // A slot freed by a same-cycle pop can take the incoming entry.
  assign push_rdy_o = !full || do_pop;
  assign do_push    = push_vld_i && push_rdy_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

  assign pop_vld_o = !empty;
  assign pop_dat_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign count_o   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Purpose : 8N1 LSB-first UART receiver for the MCU uart0_txd line, bytes delivered via a FIFO.
// Latency : byte pushed 154*DIV (+/-1) cycles after start detection, head valid one cycle later.
// Backpr. : rx_ready stalls the FIFO head; a byte arriving while full is dropped with overrun.
//
// Ports:
//   sys_clk, reset_n     clock, asynchronous active-low reset
//   uart_rxd             asynchronous serial input, idles high
//   rx_data/rx_valid     FIFO head (first-word-fall-through), rx_ready pops it
//   frame_err            one-cycle pulse when the stop bit is sampled low
//   overrun              one-cycle pulse when a received byte is dropped on a full FIFO
//   fifo_count           FIFO occupancy
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 200_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          reset_n,
  input  logic                          uart_rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV - 1);
  localparam logic [3:0]       IDX_LO    = 4'(SAMPLE_LO);
  localparam logic [3:0]       IDX_MID   = 4'(SAMPLE_MID);
  localparam logic [3:0]       IDX_HI    = 4'(SAMPLE_HI);
  localparam logic [3:0]       IDX_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizer; both stages reset to the idle level so a reset never
  // looks like a start bit.
  // ---------------------------------------------------------------------------
  logic rxd_meta_q;
  logic rxd_s_q;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Oversample tick generator, re-phased at every start detection.
  // ---------------------------------------------------------------------------
  uart_rx_state_t   state_q;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic             start_det;

  assign tick      = (tick_cnt_q == TICK_LAST);
  assign start_det = (state_q == IDLE) && !rxd_s_q;

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
    if (start_det) tick_cnt_d = '0;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) tick_cnt_q <= '0;
    else          tick_cnt_q <= tick_cnt_d;
  end

  // ---------------------------------------------------------------------------
  // Bit sampling helpers.
  // ---------------------------------------------------------------------------
  logic [3:0] idx_q;
  logic [2:0] bit_cnt_q;
  logic       smp_lo_q;
  logic       smp_mid_q;
  logic [7:0] shift_q;
  logic       frame_err_q;
  logic       overrun_q;
  logic       bit_val;
  logic       at_decide;
  logic       at_bit_end;

  // Third sample is the live synchronized value at the deciding tick.
  assign bit_val    = maj3(smp_lo_q, smp_mid_q, rxd_s_q);
  assign at_decide  = tick && (idx_q == IDX_HI);
  assign at_bit_end = tick && (idx_q == IDX_LAST);

  // Push is issued at the stop-bit decision itself so overrun lines up with it.
  logic push_vld;
  logic push_rdy;

  assign push_vld = (state_q == STOP) && at_decide && bit_val;

  // ---------------------------------------------------------------------------
  // Receive FSM with registered pulse outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      bit_cnt_q   <= '0;
      smp_lo_q    <= 1'b1;
      smp_mid_q   <= 1'b1;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= push_vld && !push_rdy;

      if (tick) begin
        idx_q <= idx_q + 4'd1;
        if (idx_q == IDX_LO)  smp_lo_q  <= rxd_s_q;
        if (idx_q == IDX_MID) smp_mid_q <= rxd_s_q;
      end

      unique case (state_q)
        IDLE: begin
          if (!rxd_s_q) begin
            idx_q   <= '0;
            state_q <= START;
          end
        end

        START: begin
          // A start bit that is high at its centre was a glitch.
          if (at_decide && bit_val) begin
            state_q <= IDLE;
          end else if (at_bit_end) begin
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end
        end

        DATA: begin
          if (at_decide) shift_q <= {bit_val, shift_q[7:1]};
          if (at_bit_end) begin
            if (bit_cnt_q == BIT_LAST) state_q   <= STOP;
            else                       bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end

        STOP: begin
          // Leaving at mid stop bit leaves half a bit of margin before the next start.
          if (at_decide) begin
            if (bit_val) begin
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end
        end

        BREAK: begin
          // Held-low line: wait for the return to idle before hunting for a start.
          if (rxd_s_q) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  // ---------------------------------------------------------------------------
  // Output FIFO.
  // ---------------------------------------------------------------------------
  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i      (sys_clk),
    .rst_ni     (reset_n),
    .push_vld_i (push_vld),
    .push_dat_i (shift_q),
    .push_rdy_o (push_rdy),
    .pop_vld_o  (rx_valid),
    .pop_dat_o  (rx_data),
    .pop_rdy_i  (rx_ready),
    .count_o    (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Purpose : scoreboard bench for uart_rx_ctrl; expected bytes queued at stimulus, popped by a monitor.
// Latency : n/a.
// Backpr. : drives rx_ready directly to exercise stall and overrun.
module tb_uart_rx_ctrl;

  localparam int CLK_HZ     = 12_000_000;
  localparam int BAUD       = 100_000;
  localparam int FIFO_DEPTH = 16;
  // (12_000_000 + 800_000) / 1_600_000 = 8 ; plain truncation would give 7.
  localparam int DIV_EXP    = 8;
  localparam int BIT_NOM    = 16 * DIV_EXP;   // 128 cycles per bit
  localparam int BIT_FAST   = 126;            // about 1.6% fast
  // Drive edge -> rxd_s low: 2 cycles, detection -> push: 154*DIV, push -> visible: 1.
  localparam int LAT_EXP    = 154 * DIV_EXP + 3;

  logic       sys_clk  = 1'b0;
  logic       reset_n  = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic [4:0] fifo_count;

  int         cyc     = 0;
  int         n_chk   = 0;
  int         n_pass  = 0;
  int         fe_seen = 0;
  int         ov_seen = 0;
  int         pop_cnt = 0;
  int         t_start = 0;
  logic [7:0] exp_q[$];

  uart_rx_ctrl #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .uart_rxd   (uart_rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_count (fifo_count)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    check(name, act, exp, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Caller is aligned 1 time unit after a rising edge; line is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bitc);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    t_start = cyc;
    for (int i = 0; i < 10; i++) begin
      uart_rxd = f[i];
      wait_cyc(bitc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rx_data"},    int'(rx_data),    0);
    check_eq({tag, "_rx_valid"},   int'(rx_valid),   0);
    check_eq({tag, "_frame_err"},  int'(frame_err),  0);
    check_eq({tag, "_overrun"},    int'(overrun),    0);
    check_eq({tag, "_fifo_count"}, int'(fifo_count), 0);
  endtask

  // Monitor: pulse counting and scoreboard comparison on every pop.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (reset_n) begin
        if (frame_err) fe_seen++;
        if (overrun)   ov_seen++;
        if (rx_valid && rx_ready) begin
          if (pop_cnt == 0) check("push_latency", cyc - t_start, LAT_EXP - 1, LAT_EXP + 1);
          pop_cnt++;
          check("sb_byte_expected", exp_q.size(), 1, 1 << 20);
          if (exp_q.size() != 0) check_eq("rx_data", int'(rx_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t2_bytes [3];
    logic [9:0] f6;
    t2_bytes = '{8'h00, 8'hFF, 8'h55};

    // Reset values, during and after reset.
    wait_cyc(4);
    check_reset_outputs("rst_hold");
    reset_n = 1'b1;
    wait_cyc(4);
    check_reset_outputs("rst_rel");

    // 1: single byte with push-latency measurement.
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, BIT_NOM);
    wait_cyc(BIT_NOM);
    check_eq("t1_pops", pop_cnt, 1);
    check_eq("t1_frame_err", fe_seen, 0);

    // 2: back-to-back frames, zero idle, fast line.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(t2_bytes[i]);
      send_frame(t2_bytes[i], 1'b1, BIT_FAST);
    end
    wait_cyc(2 * BIT_NOM);
    check_eq("t2_pops", pop_cnt, 4);
    check_eq("t2_frame_err", fe_seen, 0);

    // 3: three-tick glitch must be a false start.
    rx_ready = 1'b0;
    uart_rxd = 1'b0;
    wait_cyc(3 * DIV_EXP);
    uart_rxd = 1'b1;
    wait_cyc(20 * BIT_NOM);
    check_eq("t3_fifo_count", int'(fifo_count), 0);
    check_eq("t3_rx_valid", int'(rx_valid), 0);
    check_eq("t3_frame_err", fe_seen, 0);
    rx_ready = 1'b1;

    // 4: framing error, line held low, then a good byte.
    send_frame(8'h3C, 1'b0, BIT_NOM);
    wait_cyc(20 * BIT_NOM);
    uart_rxd = 1'b1;
    wait_cyc(BIT_NOM);
    check_eq("t4_frame_err_pulses", fe_seen, 1);
    check_eq("t4_fifo_count", int'(fifo_count), 0);
    check_eq("t4_pops_after_err", pop_cnt, 4);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, BIT_NOM);
    wait_cyc(BIT_NOM);
    check_eq("t4_pops", pop_cnt, 5);

    // 5: overrun on the 17th byte while stalled, then drain in order.
    rx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, BIT_NOM);
    end
    wait_cyc(BIT_NOM);
    check_eq("t5_fifo_count_full", int'(fifo_count), 16);
    check_eq("t5_overrun_pulses", ov_seen, 1);
    check_eq("t5_head_stable", int'(rx_data), 0);
    check_eq("t5_rx_valid", int'(rx_valid), 1);
    rx_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) wait_cyc(1);
    wait_cyc(2);
    check_eq("t5_drain_pending", exp_q.size(), 0);
    check_eq("t5_fifo_count_empty", int'(fifo_count), 0);
    check_eq("t5_pops", pop_cnt, 21);

    // 6: reset during data bit 4 of 0xC3, then 0x5A.
    f6 = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      uart_rxd = f6[i];
      wait_cyc(BIT_NOM);
    end
    uart_rxd = f6[5];
    wait_cyc(BIT_NOM / 2);
    reset_n = 1'b0;
    uart_rxd = 1'b1;
    wait_cyc(3);
    check_reset_outputs("t6_hold");
    reset_n = 1'b1;
    wait_cyc(3);
    check_reset_outputs("t6_rel");
    wait_cyc(12 * BIT_NOM);
    check_eq("t6_no_partial", pop_cnt, 21);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, BIT_NOM);
    wait_cyc(BIT_NOM);
    check_eq("t6_pops", pop_cnt, 22);
    check_eq("t6_pending", exp_q.size(), 0);

    check_eq("end_frame_err_pulses", fe_seen, 1);
    check_eq("end_overrun_pulses", ov_seen, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
